// File: rtl/immgen_pkg.sv
// Shared immediate-format definitions for the RV32I immediate generator and
// its inverse, the instruction encoder.
//   IMM_*   : format select codes on in_sel
//   OPC_*   : base opcode constants
//   enc_req_t / enc_rsp_t : request into / result out of the field packer
//   fits_signed() : true when a 32-bit value sign-extends from bit msb
package immgen_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] IMM_R = 3'b101;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    typedef struct packed {
        logic [2:0]  sel;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_req_t;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } enc_rsp_t;

    // A value fits a signed field whose sign bit is msb when every bit
    // from msb up to 31 equals bit 31.
    function automatic logic fits_signed(input logic [31:0] v, input int msb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= msb && v[i] != v[31]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Loader-side request channel plus imem write port of the instruction encoder.
//   slave  : the encoder (consumes requests, drives the write port)
//   master : the loader / assembler source and imem sink
interface instr_encoder_if #(
    parameter int AW = 10
) ();
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_sel;
    logic [6:0]    in_opcode;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [31:0]   in_imm;
    logic          addr_clr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          err;
    logic [7:0]    err_cnt;

    modport slave (
        input  in_valid, in_sel, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, addr_clr,
        output in_ready, wr_en, wr_addr, wr_data, err, err_cnt
    );

    modport master (
        output in_valid, in_sel, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, addr_clr,
        input  in_ready, wr_en, wr_addr, wr_data, err, err_cnt
    );
endinterface

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with immediate range check.
//   req : format select, opcode, register fields, funct3/7, immediate
//   rsp : encoded word and err (immediate out of range or illegal select)
module instr_pack
    import immgen_pkg::*;
(
    input  enc_req_t req,
    output enc_rsp_t rsp
);

    always_comb begin
        rsp = '0;
        case (req.sel)
            IMM_I: begin
                rsp.word = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
                rsp.err  = !fits_signed(req.imm, 11);
            end
            IMM_S: begin
                rsp.word = {req.imm[11:5], req.rs2, req.rs1, req.funct3,
                            req.imm[4:0], req.opcode};
                rsp.err  = !fits_signed(req.imm, 11);
            end
            IMM_B: begin
                // bit 0 is implicit in branch offsets, so odd values are rejected
                rsp.word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                            req.imm[4:1], req.imm[11], req.opcode};
                rsp.err  = !fits_signed(req.imm, 12) | req.imm[0];
            end
            IMM_U: begin
                rsp.word = {req.imm[31:12], req.rd, req.opcode};
                rsp.err  = |req.imm[11:0];
            end
            IMM_J: begin
                rsp.word = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                            req.rd, req.opcode};
                rsp.err  = !fits_signed(req.imm, 20) | req.imm[0];
            end
            IMM_R: begin
                rsp.word = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
            end
            default: rsp.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder / imem loader.
// Packs accepted requests into instruction words (stage 1), then writes good
// words to imem at an auto-incrementing word address (stage 2). Words whose
// immediate fails the range check are dropped and counted.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request channel, addr_clr, imem write port, err / err_cnt
module instr_encoder
    import immgen_pkg::*;
#(
    parameter int AW        = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    instr_encoder_if.slave  bus
);

    localparam logic [AW-1:0] BASE_A = AW'(BASE_ADDR);

    enc_req_t req;
    enc_rsp_t rsp;

    // vld_pipe[1]: stage-1 holds an entry; vld_pipe[2]: stage-2 write strobe
    logic [2:1]    vld_pipe_d, vld_pipe_q;
    logic [31:0]   s1_word_d, s1_word_q;
    logic          s1_err_d, s1_err_q;
    logic [31:0]   wr_data_d, wr_data_q;
    logic [AW-1:0] wr_addr_d, wr_addr_q;
    logic          err_d, err_q;
    logic [7:0]    err_cnt_d, err_cnt_q;

    logic in_ready;
    logic s2_free;
    logic accept;
    logic s1_good;
    logic s1_bad;

    assign req = '{sel:    bus.in_sel,    opcode: bus.in_opcode,
                   rd:     bus.in_rd,     rs1:    bus.in_rs1,
                   rs2:    bus.in_rs2,    funct3: bus.in_funct3,
                   funct7: bus.in_funct7, imm:    bus.in_imm};

    instr_pack u_pack (
        .req (req),
        .rsp (rsp)
    );

    always_comb begin
        // imem writes never stall, so stage 2 always drains
        s2_free  = 1'b1;
        in_ready = !vld_pipe_q[1] | s2_free;
        accept   = bus.in_valid & in_ready;
        s1_good  = vld_pipe_q[1] & !s1_err_q;
        s1_bad   = vld_pipe_q[1] &  s1_err_q;

        vld_pipe_d = {s1_good, accept};
        s1_word_d  = accept ? rsp.word : s1_word_q;
        s1_err_d   = accept ? rsp.err  : s1_err_q;

        // errored entries leave the last written data on the port
        wr_data_d  = s1_good ? s1_word_q : wr_data_q;

        err_d      = err_q | s1_bad;
        err_cnt_d  = (s1_bad && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;

        // clear beats increment; a write in the same cycle still used the old address
        if (bus.addr_clr)       wr_addr_d = BASE_A;
        else if (vld_pipe_q[2]) wr_addr_d = wr_addr_q + AW'(1);
        else                    wr_addr_d = wr_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_word_q  <= '0;
            s1_err_q   <= 1'b0;
            wr_data_q  <= '0;
            wr_addr_q  <= BASE_A;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_word_q  <= s1_word_d;
            s1_err_q   <= s1_err_d;
            wr_data_q  <= wr_data_d;
            wr_addr_q  <= wr_addr_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = vld_pipe_q[2];
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.err      = err_q;
    assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver pushes expected results
// (from a reference encoder) tagged with the cycle they must appear; the
// monitor tracks the write address, error state and compares every cycle.
module tb_instr_encoder;

    localparam int AW   = 4;
    localparam int BASE = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        int          cyc;
        bit          bad;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];

    instr_encoder_if #(.AW(AW)) bus ();

    instr_encoder #(.AW(AW), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference encoder: immediate rules as integer ranges, fields placed by shifts.
    function automatic void ref_enc(input logic [2:0] sel, input logic [6:0] op,
                                    input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [31:0] imm,
                                    output logic [31:0] w, output bit bad);
        longint v;
        logic [31:0] base;
        v    = longint'($signed(imm));
        base = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20);
        w    = 32'd0;
        bad  = 1'b0;
        case (sel)
            3'd0: begin
                bad = (v < -2048) || (v > 2047);
                w   = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                    | (32'(rd) << 7) | 32'(op);
            end
            3'd1: begin
                bad = (v < -2048) || (v > 2047);
                w   = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                    | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(op);
            end
            3'd2: begin
                bad = (v < -4096) || (v > 4094) || (imm[0] == 1'b1);
                w   = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                    | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                    | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(op);
            end
            3'd3: begin
                bad = (imm & 32'hFFF) != 32'd0;
                w   = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
            end
            3'd4: begin
                bad = (v < -1048576) || (v > 1048574) || (imm[0] == 1'b1);
                w   = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                    | (32'(rd) << 7) | 32'(op);
            end
            3'd5: w = base | (32'(f7) << 25);
            default: bad = 1'b1;
        endcase
    endfunction

    task automatic send(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic clr);
        exp_t e;
        logic [31:0] w;
        bit bad;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_sel    = sel;
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
        bus.addr_clr  = clr;
        ref_enc(sel, op, rd, rs1, rs2, f3, f7, imm, w, bad);
        e.cyc  = cyc + 2;
        e.bad  = bad;
        e.word = w;
        sb.push_back(e);
    endtask

    task automatic idle(input logic clr);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.addr_clr = clr;
    endtask

    function automatic logic [31:0] pick_imm(input logic [2:0] sel);
        int lo, hi, k;
        logic [31:0] v;
        k = int'($urandom_range(0, 5));
        case (sel)
            3'd0, 3'd1: begin lo = -2048;    hi = 2047;    end
            3'd2:       begin lo = -4096;    hi = 4094;    end
            3'd4:       begin lo = -1048576; hi = 1048574; end
            default:    begin lo = 0;        hi = 0;       end
        endcase
        case (k)
            0:       v = 32'($urandom_range(0, 255)) - 32'd128;
            1:       v = 32'(lo);
            2:       v = 32'(hi);
            3:       v = 32'(lo - 1);
            4:       v = 32'(hi + 1);
            default: v = $urandom;
        endcase
        if ((sel == 3'd2 || sel == 3'd4) && (k == 0 || k == 5) && $urandom_range(0, 3) != 0)
            v[0] = 1'b0;
        if (sel == 3'd3 && k < 4) v = v & 32'hFFFFF000;
        if (sel == 3'd3 && k < 2) v = $urandom & 32'hFFFFF000;
        return v;
    endfunction

    task automatic send_rand(input logic clr);
        int r;
        logic [2:0] sel;
        r   = int'($urandom_range(0, 15));
        sel = (r < 14) ? 3'(r % 6) : 3'(6 + (r - 14));
        send(sel, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             3'($urandom), 7'($urandom), pick_imm(sel), clr);
    endtask

    // Monitor: one pass per cycle, sampled on the falling edge.
    initial begin
        logic [AW-1:0] exp_addr;
        bit            exp_err;
        int            exp_cnt;
        bit            wr_exp;
        logic [31:0]   wd;
        exp_t          e;
        exp_addr = AW'(BASE);
        exp_err  = 1'b0;
        exp_cnt  = 0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                exp_addr = AW'(BASE);
                exp_err  = 1'b0;
                exp_cnt  = 0;
                chk("rst_wr_en",   32'(bus.wr_en),   32'd0);
                chk("rst_wr_data", bus.wr_data,      32'd0);
                chk("rst_wr_addr", 32'(bus.wr_addr), 32'(BASE));
                chk("rst_err",     32'(bus.err),     32'd0);
                chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
            end else begin
                wr_exp = 1'b0;
                wd     = 32'd0;
                if (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    chk("sched_missed", 32'(cyc), 32'(e.cyc));
                end
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    if (e.bad) begin
                        exp_err = 1'b1;
                        if (exp_cnt < 255) exp_cnt++;
                    end else begin
                        wr_exp = 1'b1;
                        wd     = e.word;
                    end
                end
                chk("wr_en", 32'(bus.wr_en), 32'(wr_exp));
                if (wr_exp) chk("wr_data", bus.wr_data, wd);
                chk("wr_addr",  32'(bus.wr_addr),  32'(exp_addr));
                chk("err",      32'(bus.err),      32'(exp_err));
                chk("err_cnt",  32'(bus.err_cnt),  32'(exp_cnt));
                chk("in_ready", 32'(bus.in_ready), 32'd1);
                if (bus.addr_clr)  exp_addr = AW'(BASE);
                else if (wr_exp)   exp_addr = exp_addr + AW'(1);
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_opcode = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_funct3 = '0;
        bus.in_funct7 = '0;
        bus.in_imm    = '0;
        bus.addr_clr  = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;

        // I, max positive immediate, lands at BASE
        send(3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047, 1'b0);
        repeat (3) idle(1'b0);

        // S / B / J back to back, then U, then an odd branch offset (dropped)
        send(3'd1, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd24, 1'b0);
        send(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd32, 1'b0);
        send(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4,    1'b0);
        send(3'd3, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0);
        send(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,    1'b0);
        send(3'd5, 7'h33, 5'd3, 5'd4, 5'd5, 3'd7, 7'h20, 32'd0,   1'b0);
        repeat (3) idle(1'b0);

        // addr_clr coincident with the write at BASE+2
        idle(1'b1);
        send(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd1,  1'b0);
        send(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2,  1'b0);
        send(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd3,  1'b0);
        send(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd4,  1'b0);
        send(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5,  1'b1);
        send(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, -32'sd2048, 1'b0);
        repeat (3) idle(1'b0);

        // random traffic; address wraps many times at AW=4
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 19) == 0);
            else                           send_rand($urandom_range(0, 24) == 0);
        end
        repeat (3) idle(1'b0);

        // saturate the error counter with illegal selects
        for (int i = 0; i < 260; i++)
            send(3'(6 + (i % 2)), 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
        send(3'd0, 7'h13, 5'd7, 5'd8, 5'd0, 3'd0, 7'd0, 32'd100, 1'b0);
        repeat (3) idle(1'b0);

        // reset with two words in flight
        send(3'd0, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd10, 1'b0);
        send(3'd0, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd20, 1'b0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;
        send(3'd3, 7'h17, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 1'b0);
        send(3'd0, 7'h13, 5'd3, 5'd3, 5'd0, 3'd0, 7'd0, -32'sd1, 1'b0);
        repeat (4) idle(1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
